// File: rtl/fb_gen_if.sv
// Signal bundle between the DRSSTC interrupter side and the feedback front-end.
// The master drives enable and the raw comparator pins; the slave returns phase and flags.
interface fb_gen_if;
  logic en;
  logic fb_raw;
  logic ocd_raw;
  logic gen;
  logic ocd;
  logic locked;

  modport master (output en, fb_raw, ocd_raw, input gen, ocd, locked);
  modport slave  (input en, fb_raw, ocd_raw, output gen, ocd, locked);
endinterface

// File: rtl/fb_gen.sv
// DRSSTC feedback front-end: syncs/deglitches CT feedback, runs a startup oscillator
// until lock, and produces a filtered, stretched overcurrent flag.
module fb_gen #(
  parameter int CLK_MHZ        = 100,
  parameter int START_FREQ_KHZ = 250,
  parameter int GLITCH_CLK     = 3,
  parameter int LOCK_EDGES     = 2,
  parameter int TIMEOUT_CLK    = 1000,
  parameter int OCD_FILTER_CLK = 4,
  parameter int OCD_HOLD_CLK   = 50
) (
  input logic     clk,
  input logic     rst_n,
  fb_gen_if.slave bus
);

  localparam int HALF  = CLK_MHZ * 1000 / (2 * START_FREQ_KHZ);
  localparam int OSC_W = $clog2(HALF + 1);
  localparam int GL_W  = $clog2(GLITCH_CLK + 1);
  localparam int ED_W  = $clog2(LOCK_EDGES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CLK + 1);
  localparam int FI_W  = $clog2(OCD_FILTER_CLK + 1);
  localparam int HO_W  = $clog2(OCD_HOLD_CLK + 1);

  localparam logic [OSC_W-1:0] OSC_LAST = OSC_W'(HALF - 1);
  localparam logic [GL_W-1:0]  GL_LAST  = GL_W'(GLITCH_CLK - 1);
  localparam logic [ED_W-1:0]  ED_LAST  = ED_W'(LOCK_EDGES - 1);
  localparam logic [ED_W-1:0]  ED_MAX   = ED_W'(LOCK_EDGES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLK - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CLK);
  localparam logic [FI_W-1:0]  FI_MAX   = FI_W'(OCD_FILTER_CLK);
  localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(OCD_HOLD_CLK);

  typedef enum logic [1:0] {IDLE, START, LOCK} state_t;

  logic fb_m, fb_s, ocd_m, ocd_s;
  logic fb_f, fb_edge;
  logic [GL_W-1:0]  gl_cnt;
  logic [OSC_W-1:0] osc_cnt;
  logic [ED_W-1:0]  edge_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [FI_W-1:0]  filt_cnt, filt_nx;
  logic [HO_W-1:0]  hold_cnt;
  logic             ocd_q;
  state_t           state, state_nx;
  logic             gen_q, gen_nx, locked_q, locked_nx;
  logic             osc_wrap, lock_hit, timeout_hit;

  // Two-flop synchronizers for both asynchronous comparator inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_m  <= 1'b0;
      fb_s  <= 1'b0;
      ocd_m <= 1'b0;
      ocd_s <= 1'b0;
    end else begin
      fb_m  <= bus.fb_raw;
      fb_s  <= fb_m;
      ocd_m <= bus.ocd_raw;
      ocd_s <= ocd_m;
    end
  end

  // fb_edge is high on the cycle fb_f is about to take the new level
  assign fb_edge = (fb_s != fb_f) && (gl_cnt == GL_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_f   <= 1'b0;
      gl_cnt <= '0;
    end else if (fb_s == fb_f) begin
      gl_cnt <= '0;
    end else if (fb_edge) begin
      fb_f   <= fb_s;
      gl_cnt <= '0;
    end else begin
      gl_cnt <= gl_cnt + 1'b1;
    end
  end

  assign osc_wrap    = (osc_cnt == OSC_LAST);
  assign lock_hit    = fb_edge && (edge_cnt == ED_LAST);
  assign timeout_hit = !fb_edge && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gen_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_nx;
      gen_q    <= gen_nx;
      locked_q <= locked_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!bus.en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = START;
        START:   if (lock_hit) state_nx = LOCK;
        LOCK:    if (timeout_hit) state_nx = START;
        default: state_nx = IDLE;
      endcase
    end
  end

  // On the lock cycle fb_s already equals fb_f's next value
  always_comb begin
    gen_nx    = 1'b0;
    locked_nx = 1'b0;
    case (state_nx)
      START: gen_nx = (state == START) ? (gen_q ^ osc_wrap) : 1'b1;
      LOCK: begin
        locked_nx = 1'b1;
        gen_nx    = (state == START) ? fb_s : fb_f;
      end
      default: gen_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      osc_cnt  <= '0;
      edge_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (state == START && state_nx == START) begin
        osc_cnt <= osc_wrap ? '0 : osc_cnt + 1'b1;
        if (fb_edge && edge_cnt != ED_MAX) edge_cnt <= edge_cnt + 1'b1;
      end else begin
        osc_cnt  <= '0;
        edge_cnt <= '0;
      end
      if (state == LOCK && state_nx == LOCK) begin
        if (fb_edge)               to_cnt <= '0;
        else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Overcurrent path runs regardless of FSM state
  always_comb begin
    filt_nx = '0;
    if (ocd_s) filt_nx = (filt_cnt == FI_MAX) ? filt_cnt : filt_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_cnt <= '0;
      hold_cnt <= '0;
      ocd_q    <= 1'b0;
    end else begin
      filt_cnt <= filt_nx;
      if (filt_nx == FI_MAX) begin
        ocd_q    <= 1'b1;
        hold_cnt <= HO_LOAD;
      end else if (!ocd_s && ocd_q) begin
        if (hold_cnt <= HO_W'(1)) begin
          hold_cnt <= '0;
          ocd_q    <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.gen    = gen_q;
  assign bus.ocd    = ocd_q;
  assign bus.locked = locked_q;

endmodule

// File: tb/tb_fb_gen.sv
// Directed bench for fb_gen: startup oscillator, lock, deglitch, timeout, OCD and reset/enable.
module tb_fb_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  fb_gen_if bus ();

  fb_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // 300 kHz feedback: rises at 0, 333, 666..., 167-clock high / 166-clock low
  function automatic logic fb_at(input int k);
    return (k % 333) < 167;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.fb_raw = 1'b0;
    bus.ocd_raw = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.gen !== 1'b0) $display("FAIL reset_gen got=%b exp=0", bus.gen); else n_pass++;
    n_checks++; if (bus.ocd !== 1'b0) $display("FAIL reset_ocd got=%b exp=0", bus.ocd); else n_pass++;
    n_checks++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", bus.locked); else n_pass++;
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++; if (bus.gen !== 1'b0) $display("FAIL idle_gen got=%b exp=0", bus.gen); else n_pass++;
  endtask

  task automatic test_startup;
    logic exp_gen;
    bus.en = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      tick();
      exp_gen = ((k / 200) % 2) == 0;
      n_checks++;
      if (bus.gen !== exp_gen) $display("FAIL startup_gen k=%0d got=%b exp=%b", k, bus.gen, exp_gen);
      else n_pass++;
      n_checks++;
      if (bus.locked !== 1'b0) $display("FAIL startup_locked k=%0d got=%b exp=0", k, bus.locked);
      else n_pass++;
    end
  endtask

  task automatic test_lock;
    for (int k = 0; k < 666; k++) begin
      bus.fb_raw = fb_at(k);
      tick();
      if (k == 170) begin
        n_checks++; if (bus.locked !== 1'b0) $display("FAIL lock_early got=%b exp=0", bus.locked); else n_pass++;
      end
      if (k == 171) begin
        n_checks++; if (bus.locked !== 1'b1) $display("FAIL lock_rise got=%b exp=1", bus.locked); else n_pass++;
        n_checks++; if (bus.gen !== 1'b0) $display("FAIL lock_gen got=%b exp=0", bus.gen); else n_pass++;
      end
      if (k >= 172) begin
        n_checks++;
        if (bus.gen !== fb_at(k - 5)) $display("FAIL lock_track k=%0d got=%b exp=%b", k, bus.gen, fb_at(k - 5));
        else n_pass++;
        n_checks++;
        if (bus.locked !== 1'b1) $display("FAIL lock_hold k=%0d got=%b exp=1", k, bus.locked);
        else n_pass++;
      end
    end
  endtask

  task automatic test_glitch;
    logic exp_gen;
    for (int p = 0; p < 5; p++) begin
      for (int j = 0; j < 8; j++) begin
        bus.fb_raw = (j < 2);
        tick();
        n_checks++;
        if (bus.gen !== 1'b0 || bus.locked !== 1'b1)
          $display("FAIL glitch_reject p=%0d j=%0d got=%b%b exp=01", p, j, bus.locked, bus.gen);
        else n_pass++;
      end
    end
    for (int j = 0; j < 10; j++) begin
      bus.fb_raw = (j < 3);
      tick();
      exp_gen = (j >= 5 && j <= 7);
      n_checks++;
      if (bus.gen !== exp_gen) $display("FAIL glitch_pass j=%0d got=%b exp=%b", j, bus.gen, exp_gen);
      else n_pass++;
    end
  endtask

  // Last accepted edge was 7 ticks into the 3-clock pulse; this starts 3 ticks after it
  task automatic test_feedback_loss;
    bus.fb_raw = 1'b0;
    for (int t = 3; t <= 1200; t++) begin
      tick();
      if (t == 999) begin
        n_checks++;
        if (bus.locked !== 1'b1 || bus.gen !== 1'b0)
          $display("FAIL loss_before got=%b%b exp=10", bus.locked, bus.gen);
        else n_pass++;
      end
      if (t == 1000) begin
        n_checks++;
        if (bus.locked !== 1'b0 || bus.gen !== 1'b1)
          $display("FAIL loss_fallback got=%b%b exp=01", bus.locked, bus.gen);
        else n_pass++;
      end
      if (t == 1199) begin
        n_checks++; if (bus.gen !== 1'b1) $display("FAIL loss_osc_high got=%b exp=1", bus.gen); else n_pass++;
      end
      if (t == 1200) begin
        n_checks++; if (bus.gen !== 1'b0) $display("FAIL loss_osc_low got=%b exp=0", bus.gen); else n_pass++;
      end
    end
  endtask

  task automatic test_ocd;
    logic exp_ocd;
    bus.ocd_raw = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 16; k++) begin
      bus.ocd_raw = (k < 3);
      tick();
      n_checks++;
      if (bus.ocd !== 1'b0) $display("FAIL ocd_short k=%0d got=%b exp=0", k, bus.ocd);
      else n_pass++;
    end
    for (int k = 0; k < 70; k++) begin
      bus.ocd_raw = (k < 10);
      tick();
      exp_ocd = (k >= 5 && k <= 60);
      n_checks++;
      if (bus.ocd !== exp_ocd) $display("FAIL ocd_stretch k=%0d got=%b exp=%b", k, bus.ocd, exp_ocd);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_lock;
    for (int k = 0; k <= 340; k++) begin
      bus.fb_raw = fb_at(k);
      bus.ocd_raw = (k >= 300 && k < 310);
      tick();
    end
    n_checks++;
    if (bus.locked !== 1'b1 || bus.gen !== 1'b1 || bus.ocd !== 1'b1)
      $display("FAIL prereset got=%b%b%b exp=111", bus.locked, bus.gen, bus.ocd);
    else n_pass++;
    rst_n = 1'b0;
    bus.fb_raw = 1'b0;
    bus.ocd_raw = 1'b0;
    tick();
    n_checks++; if (bus.gen !== 1'b0) $display("FAIL midreset_gen got=%b exp=0", bus.gen); else n_pass++;
    n_checks++; if (bus.ocd !== 1'b0) $display("FAIL midreset_ocd got=%b exp=0", bus.ocd); else n_pass++;
    n_checks++; if (bus.locked !== 1'b0) $display("FAIL midreset_locked got=%b exp=0", bus.locked); else n_pass++;
    tick();
  endtask

  task automatic test_en_drop;
    rst_n = 1'b1;
    bus.en = 1'b1;
    tick();
    n_checks++; if (bus.gen !== 1'b1) $display("FAIL restart_gen got=%b exp=1", bus.gen); else n_pass++;
    repeat (49) tick();
    bus.en = 1'b0;
    tick();
    n_checks++;
    if (bus.gen !== 1'b0 || bus.locked !== 1'b0)
      $display("FAIL endrop got=%b%b exp=00", bus.locked, bus.gen);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (bus.gen !== 1'b0) $display("FAIL idle_hold k=%0d got=%b exp=0", k, bus.gen); else n_pass++;
    end
    bus.en = 1'b1;
    for (int k = 0; k <= 200; k++) begin
      tick();
      if (k == 0 || k == 199) begin
        n_checks++; if (bus.gen !== 1'b1) $display("FAIL reen_high k=%0d got=%b exp=1", k, bus.gen); else n_pass++;
      end
      if (k == 200) begin
        n_checks++; if (bus.gen !== 1'b0) $display("FAIL reen_low got=%b exp=0", bus.gen); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_lock();
    test_glitch();
    test_feedback_loss();
    test_ocd();
    test_reset_mid_lock();
    test_en_drop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_gen.md
# fb_gen

Feedback front-end for the DRSSTC controller. It produces the resonant-phase `gen` signal and the filtered overcurrent flag `ocd` that the interrupter consumes. It synchronizes and deglitches the raw current-transformer comparator. While feedback is absent it drives `gen` from an internal startup oscillator, and it hands over to real feedback once lock is detected. It sits between the analog comparator pins and the interrupter.

## Interface
- `CLK_MHZ`, 100, system clock frequency in MHz
- `START_FREQ_KHZ`, 250, startup oscillator frequency; half-period HALF = CLK_MHZ*1000/(2*START_FREQ_KHZ) clocks (200 at defaults)
- `GLITCH_CLK`, 3, consecutive equal synced samples required to accept a feedback level change
- `LOCK_EDGES`, 2, accepted feedback edges in START needed to enter LOCK
- `TIMEOUT_CLK`, 1000, clocks without an accepted feedback edge before LOCK falls back to START
- `OCD_FILTER_CLK`, 4, consecutive high synced samples required to assert `ocd`
- `OCD_HOLD_CLK`, 50, clocks `ocd` stays high after synced OCD input returns low
- `clk`  input  1  system clock, all logic on rising edge
- `rst_n`  input  1  synchronous reset, active low
- `en`  input  1  drive enable from control logic (already synchronous)
- `fb_raw`  input  1  CT comparator output, asynchronous
- `ocd_raw`  input  1  overcurrent comparator output, asynchronous
- `gen`  output  1  phase signal to the interrupter, registered
- `ocd`  output  1  filtered overcurrent flag to the interrupter, registered
- `locked`  output  1  high while in LOCK, registered

## Operation
- **Input sync.** `fb_raw` and `ocd_raw` each pass through a 2-FF synchronizer (`fb_s`, `ocd_s`).
- **Deglitch.** `fb_f` is a register, reset 0. `fb_f` takes the value of `fb_s` only after `fb_s` has differed from `fb_f` for GLITCH_CLK consecutive cycles. The run counter clears whenever `fb_s` equals `fb_f`. An accepted edge is the one-cycle event where `fb_f` changes.
- **States.** IDLE, START, LOCK.
  - **IDLE.** `gen`=0, `locked`=0, all counters cleared. When `en`=1, go to START and set `gen`=1. The oscillator counter starts at 0.
  - **START.** `gen` toggles each time the oscillator counter reaches HALF-1; the counter then wraps to 0. Accepted edges are counted. When an accepted edge brings the count to LOCK_EDGES, go to LOCK; on that same cycle `gen` takes `fb_f`'s new value and the edge count is cleared.
  - **LOCK.** `gen` follows `fb_f` one cycle later, as a registered copy. The timeout counter clears on every accepted edge and otherwise increments. When it reaches TIMEOUT_CLK-1, go to START, set `gen`=1, clear the oscillator counter and clear the edge count.
  - **Any state.** `en`=0 forces IDLE on the next cycle with `gen`=0. `en` takes priority over every other transition on the same cycle.
- **Simultaneous events in START.** If an accepted edge and an oscillator toggle fall on the same cycle and the edge completes lock, lock wins and `gen` takes `fb_f`.
- **Simultaneous events in LOCK.** If an accepted edge and a timeout fall on the same cycle, the edge wins and the state stays LOCK.
- **OCD filter.** A filter counter saturates at OCD_FILTER_CLK while `ocd_s`=1 and clears while `ocd_s`=0. When the counter reaches OCD_FILTER_CLK, `ocd` is set and the hold counter loads OCD_HOLD_CLK.
- **OCD hold.** While `ocd_s`=0 and `ocd`=1, the hold counter decrements, and `ocd` clears on the cycle it reaches 0. A new qualified high reloads the hold counter.
- **OCD is independent of FSM.** The OCD path runs in every state, including IDLE.
- **Counter widths.** `$clog2(max value + 1)` for each counter. All counters saturate and never wrap, except the oscillator counter.
- **Reset.** `rst_n`=0 on a clock edge puts the block in IDLE and clears every counter. The synchronizers, `fb_f`, `gen`, `ocd` and `locked` all go to 0. Reset applied in the middle of a state or hold behaves identically.

## Timing
- **Feedback latency in LOCK.** From a `fb_raw` level change to `gen`: 2 (sync) + GLITCH_CLK (deglitch) + 1 (output register) = 6 cycles at defaults.
- **`locked`.** Asserts on the same cycle `gen` first takes `fb_f`.
- **Startup.** The first `gen` high appears 1 cycle after `en` is sampled high. The period is 2*HALF clocks with 50 % duty.
- **OCD assertion latency.** 2 + OCD_FILTER_CLK = 6 cycles from `ocd_raw` rising.
- **OCD release.** `ocd` deasserts OCD_HOLD_CLK cycles after `ocd_s` falls.
- **Outputs.** All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Startup with no feedback.** Reset, then `en`=1 with `fb_raw`=0. Required: `gen` square wave with 200-clock high and 200-clock low phases; `locked` stays 0 for 10 periods.
- **Lock acquisition.** In START, drive `fb_raw` at 300 kHz (166/167-clock halves). Required: `locked` rises on the 2nd accepted edge; `gen` then tracks `fb_raw` with 6-cycle latency.
- **Glitch rejection.** In LOCK, apply 2-clock pulses on `fb_raw`. Required: no `gen` change. A 3-clock-stable change is passed through.
- **Feedback loss.** Stop `fb_raw` while in LOCK. Required: `locked` drops and the oscillator restarts with `gen`=1 after 1000 clocks without an accepted edge.
- **OCD filter and stretch.** Pulse `ocd_raw` high for 3 clocks: `ocd` stays 0. Hold it high for 10 clocks: `ocd` rises 6 cycles after the rising edge and falls 50 cycles after `ocd_s` falls.
- **Reset and enable priority.** Assert `rst_n`=0 mid-LOCK: all outputs 0 next cycle. Drop `en` during START: `gen`=0 next cycle and the state is IDLE.
